// File: rtl/parity_frame_checker.sv
// parity_frame_checker: re-checks byte parity and reports per-frame length, XOR checksum and error counts (optional stats via PARITY_FRAME_CHECKER_STATS_EN)
module parity_frame_checker #(
  parameter bit ODD = 1'b0,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_parity,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_error,
  output logic [LEN_W-1:0] out_len,
  output logic [7:0]       out_xor,
`ifdef PARITY_FRAME_CHECKER_STATS_EN
  output logic [LEN_W-1:0] out_bad_cnt,
  input  logic             stats_clr,
  output logic [15:0]      stat_frames,
  output logic [15:0]      stat_err_frames
`else
  output logic [LEN_W-1:0] out_bad_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;
  localparam logic [LEN_W-1:0] MAX = '1;
  state_t state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, bad_q, bad_d;
  logic [7:0] xor_q, xor_d;
  logic err_q, err_d;
  logic accept, bad, first;
  assign in_ready = state_q != REPORT;
  assign out_valid = state_q == REPORT;
  assign accept = in_valid & in_ready;
  assign bad = in_parity != (^in_data ^ ODD);
  assign first = state_q == IDLE;
  assign out_error = err_q;
  assign out_len = len_q;
  assign out_xor = xor_q;
  assign out_bad_cnt = bad_q;
  // next state and accumulator update; the first byte of a frame reloads everything
  always_comb begin
    state_d = state_q;
    len_d = len_q;
    bad_d = bad_q;
    xor_d = xor_q;
    err_d = err_q;
    if (accept) begin
      len_d = first ? LEN_W'(1) : (len_q == MAX ? len_q : len_q + LEN_W'(1));
      bad_d = first ? LEN_W'(bad) : (bad_q == MAX || !bad ? bad_q : bad_q + LEN_W'(1));
      xor_d = first ? in_data : xor_q ^ in_data;
      err_d = bad | (!first & err_q);
      state_d = in_last ? REPORT : ACCUM;
    end
    if (out_valid && out_ready) state_d = IDLE;
  end
  // state and accumulator registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      len_q <= '0;
      bad_q <= '0;
      xor_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      bad_q <= bad_d;
      xor_q <= xor_d;
      err_q <= err_d;
    end
  end
`ifdef PARITY_FRAME_CHECKER_STATS_EN
  logic hs;
  assign hs = out_valid & out_ready;
  // saturating frame counters; clear wins over a simultaneous handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst || stats_clr) begin
      stat_frames <= '0;
      stat_err_frames <= '0;
    end else if (hs) begin
      stat_frames <= &stat_frames ? stat_frames : stat_frames + 16'd1;
      stat_err_frames <= (&stat_err_frames || !err_q) ? stat_err_frames : stat_err_frames + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_parity_frame_checker.sv
// tb_parity_frame_checker: randomized frames against a frame-level model, two configurations driven in parallel
module tb_parity_frame_checker;
  logic clk = 0, rst = 1, in_valid = 0, in_parity = 0, in_last = 0, out_ready = 0, stats_clr = 0;
  logic [7:0] in_data = 0;
  logic rdy0, val0, err0, rdy1, val1, err1;
  logic [7:0] len0, bad0, x0, x1;
  logic [1:0] len1, bad1;
  logic [15:0] sf0, se0, sf1, se1;
  int nvec = 0, nerr = 0;
  byte unsigned fd[$];
  bit fp[$];
  wire [25:0] obs0 = {val0, err0, len0, x0, bad0};
  wire [25:0] obs1 = {val1, err1, 6'b0, len1, x1, 6'b0, bad1};
  always #5 clk = ~clk;
  parity_frame_checker #(.ODD(1'b0), .LEN_W(8)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
    .in_parity(in_parity), .in_last(in_last), .out_valid(val0), .out_ready(out_ready),
    .out_error(err0), .out_len(len0), .out_xor(x0),
`ifdef PARITY_FRAME_CHECKER_STATS_EN
    .stats_clr(stats_clr), .stat_frames(sf0), .stat_err_frames(se0),
`endif
    .out_bad_cnt(bad0));
  parity_frame_checker #(.ODD(1'b1), .LEN_W(2)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
    .in_parity(in_parity), .in_last(in_last), .out_valid(val1), .out_ready(out_ready),
    .out_error(err1), .out_len(len1), .out_xor(x1),
`ifdef PARITY_FRAME_CHECKER_STATS_EN
    .stats_clr(stats_clr), .stat_frames(sf1), .stat_err_frames(se1),
`endif
    .out_bad_cnt(bad1));
`ifndef PARITY_FRAME_CHECKER_STATS_EN
  assign {sf0, se0, sf1, se1} = '0;
`endif

  function automatic logic [25:0] model(input bit odd, input int lw);
    int mx, b, n;
    logic [7:0] x;
    mx = (1 << lw) - 1;
    b = 0;
    x = 0;
    n = fd.size();
    foreach (fd[i]) begin
      x ^= fd[i];
      if (fp[i] != ((^fd[i]) ^ odd)) b++;
    end
    return {1'b1, b != 0, 8'(n > mx ? mx : n), x, 8'(b > mx ? mx : b)};
  endfunction

  task automatic send_frame();
    foreach (fd[i]) begin
      while ($urandom_range(0, 3) == 0) begin
        in_valid = 0;
        in_data = 8'($urandom);
        @(negedge clk);
      end
      in_valid = 1;
      in_data = fd[i];
      in_parity = fp[i];
      in_last = (i == fd.size() - 1);
      @(negedge clk);
    end
    in_valid = 0;
    in_last = 0;
  endtask

  task automatic drain();
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    nvec++;
    if (obs0 !== 26'd0 || obs1 !== 26'd0 || rdy0 !== 1'b1 || rdy1 !== 1'b1) begin
      nerr++;
      $display("FAIL reset got %h/%h rdy %b%b want 0/0 rdy 11", obs0, obs1, rdy0, rdy1);
    end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_good_frame(input bit p2);
    fd = '{8'h01, 8'h03, 8'hFF};
    fp = '{1'b1, p2, 1'b0};
    send_frame();
    nvec++;
    if (obs0 !== model(0, 8)) begin nerr++; $display("FAIL frame3_u0 got %h want %h", obs0, model(0, 8)); end
    nvec++;
    if (obs0 !== {1'b1, p2, 8'd3, 8'hFD, 7'd0, p2}) begin nerr++; $display("FAIL frame3_const got %h want %h", obs0, {1'b1, p2, 8'd3, 8'hFD, 7'd0, p2}); end
    nvec++;
    if (obs1 !== model(1, 2)) begin nerr++; $display("FAIL frame3_u1 got %h want %h", obs1, model(1, 2)); end
    drain();
  endtask

  task automatic test_backpressure();
    logic [25:0] e0;
    fd = '{8'h80};
    fp = '{1'b1};
    e0 = model(0, 8);
    send_frame();
    for (int k = 0; k < 5; k++) begin
      in_valid = 1;
      in_data = 8'($urandom);
      in_parity = 1'($urandom);
      in_last = 1;
      nvec++;
      if (obs0 !== e0 || obs1 !== model(1, 2) || rdy0 !== 1'b0 || rdy1 !== 1'b0) begin
        nerr++;
        $display("FAIL stall%0d got %h/%h rdy %b%b want %h/%h rdy 00", k, obs0, obs1, rdy0, rdy1, e0, model(1, 2));
      end
      @(negedge clk);
    end
    in_valid = 0;
    in_last = 0;
    drain();
    nvec++;
    if (val0 !== 1'b0 || rdy0 !== 1'b1 || val1 !== 1'b0 || rdy1 !== 1'b1) begin
      nerr++;
      $display("FAIL after_hs got val %b%b rdy %b%b want val 00 rdy 11", val0, val1, rdy0, rdy1);
    end
    nvec++;
    if (x0 !== 8'h80 || len0 !== 8'd1) begin nerr++; $display("FAIL hold_idle got len %0d xor %h want 1 80", len0, x0); end
  endtask

  task automatic test_odd();
    for (int p = 1; p >= 0; p--) begin
      fd = '{8'h00};
      fp = '{1'(p)};
      send_frame();
      nvec++;
      if (err1 !== (p == 0) || obs1 !== model(1, 2)) begin nerr++; $display("FAIL odd_p%0d got %h want %h", p, obs1, model(1, 2)); end
      nvec++;
      if (obs0 !== model(0, 8)) begin nerr++; $display("FAIL even_p%0d got %h want %h", p, obs0, model(0, 8)); end
      drain();
    end
  endtask

  task automatic test_saturate(input int n);
    fd = {};
    fp = {};
    for (int i = 0; i < n; i++) begin
      fd.push_back(n == 6 ? 8'h11 : 8'($urandom));
      fp.push_back(n == 6 ? 1'b0 : ^fd[i]);
    end
    send_frame();
    nvec++;
    if (obs0 !== model(0, 8)) begin nerr++; $display("FAIL sat%0d_u0 got %h want %h", n, obs0, model(0, 8)); end
    nvec++;
    if (obs1 !== model(1, 2)) begin nerr++; $display("FAIL sat%0d_u1 got %h want %h", n, obs1, model(1, 2)); end
    drain();
  endtask

  task automatic test_random();
    for (int f = 0; f < 25; f++) begin
      fd = {};
      fp = {};
      for (int i = 0; i < int'($urandom_range(1, 9)); i++) begin
        fd.push_back(8'($urandom));
        fp.push_back(1'($urandom));
      end
      send_frame();
      nvec++;
      if (obs0 !== model(0, 8)) begin nerr++; $display("FAIL rand%0d_u0 got %h want %h", f, obs0, model(0, 8)); end
      nvec++;
      if (obs1 !== model(1, 2)) begin nerr++; $display("FAIL rand%0d_u1 got %h want %h", f, obs1, model(1, 2)); end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      drain();
      nvec++;
      if (val0 !== 1'b0 || rdy0 !== 1'b1) begin nerr++; $display("FAIL rand%0d_hs got val %b rdy %b want 0 1", f, val0, rdy0); end
    end
  endtask

  task automatic test_abort();
    for (int i = 0; i < 2; i++) begin
      in_valid = 1;
      in_data = 8'($urandom);
      in_parity = 1'($urandom);
      in_last = 0;
      @(negedge clk);
    end
    in_valid = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    nvec++;
    if (obs0 !== 26'd0 || obs1 !== 26'd0) begin nerr++; $display("FAIL abort_rst got %h/%h want 0/0", obs0, obs1); end
    fd = '{8'h05};
    fp = '{1'b0};
    send_frame();
    nvec++;
    if (obs0 !== {1'b1, 1'b0, 8'd1, 8'h05, 8'd0}) begin nerr++; $display("FAIL abort_u0 got %h want %h", obs0, {1'b1, 1'b0, 8'd1, 8'h05, 8'd0}); end
    nvec++;
    if (obs1 !== model(1, 2)) begin nerr++; $display("FAIL abort_u1 got %h want %h", obs1, model(1, 2)); end
    drain();
`ifdef PARITY_FRAME_CHECKER_STATS_EN
    nvec++;
    if (sf0 !== 16'd1 || se0 !== 16'd0 || sf1 !== 16'd1 || se1 !== 16'd1) begin
      nerr++;
      $display("FAIL stats got %0d %0d %0d %0d want 1 0 1 1", sf0, se0, sf1, se1);
    end
    stats_clr = 1;
    @(negedge clk);
    stats_clr = 0;
    nvec++;
    if ({sf0, se0, sf1, se1} !== 64'd0) begin nerr++; $display("FAIL stats_clr got %0d %0d %0d %0d want 0", sf0, se0, sf1, se1); end
`endif
  endtask

  initial begin
    test_reset();
    test_good_frame(1'b0);
    test_good_frame(1'b1);
    test_backpressure();
    test_odd();
    test_saturate(6);
    test_saturate(300);
    test_random();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
